// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if: request, data-buffer and line signals of the USB transmit encoder.
interface usb_tx_encoder_if;
  logic [1:0] TX_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] TX_packet_data;
  logic       get_TX_packet_data;
  logic       dp_out;
  logic       dm_out;
  logic       TX_transfer_active;
  logic       TX_error;
  modport master (
    output TX_packet, buffer_occupancy, TX_packet_data,
    input  get_TX_packet_data, dp_out, dm_out, TX_transfer_active, TX_error
  );
  modport slave (
    input  TX_packet, buffer_occupancy, TX_packet_data,
    output get_TX_packet_data, dp_out, dm_out, TX_transfer_active, TX_error
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: serialises SYNC/PID/DATA0 payload/CRC16 with bit stuffing and NRZI,
// then drives EOP; handshake packets ACK/NAK skip payload and CRC.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input logic            clk,
  input logic            n_rst,
  usb_tx_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP} state_t;
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    bit_q, bit_d, bit_n;
  logic [2:0]    ones_q, ones_d, ones_n;
  logic          stuff_q, stuff_d, lvl_q, lvl_d;
  logic [7:0]    sh_q, sh_d, src;
  logic [15:0]   crc_q, crc_d, crc_b;
  logic [1:0]    pkt_q, pkt_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          busy, bit_end, load, cur, drv, more;
  always_comb begin
    busy = state_q != IDLE;
    bit_end = tmr_q == TW'(CLKS_PER_BIT - 1);
    // the payload byte is popped in the first cycle of its first bit and drives the line at once
    load = state_q == DATA && bit_q == 4'd0 && tmr_q == '0 && !stuff_q;
    src = load ? bus.TX_packet_data : sh_q;
    cur = !stuff_q && src[0];
    drv = cur ? lvl_q : ~lvl_q;
    crc_b = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ cur) ? 16'hA001 : 16'h0000);
    more = bus.buffer_occupancy != 7'd0 && cnt_q != 7'd64;
    ones_n = cur ? ones_q + 3'd1 : 3'd0;
    bit_n = stuff_q ? bit_q : bit_q + 4'd1;
    state_d = state_q;
    tmr_d = busy && !bit_end ? tmr_q + 1'b1 : '0;
    bit_d = bit_q;
    ones_d = ones_q;
    stuff_d = stuff_q;
    lvl_d = lvl_q;
    sh_d = src;
    crc_d = crc_q;
    pkt_d = pkt_q;
    cnt_d = cnt_q + 7'(load);
    if (state_q == IDLE) begin
      if (bus.TX_packet != 2'd0) begin
        state_d = SYNC;
        pkt_d = bus.TX_packet;
        sh_d = 8'h80;
        bit_d = 4'd0;
        ones_d = 3'd0;
        stuff_d = 1'b0;
        lvl_d = 1'b1;
        crc_d = 16'hFFFF;
        cnt_d = 7'd0;
      end
    end else if (state_q == EOP) begin
      if (bit_end) begin
        bit_d = bit_q == 4'd2 ? 4'd0 : bit_q + 4'd1;
        state_d = bit_q == 4'd2 ? IDLE : EOP;
      end
    end else if (bit_end) begin
      lvl_d = drv;
      ones_d = ones_n;
      bit_d = bit_n;
      stuff_d = 1'b0;
      if (!stuff_q) begin
        sh_d = src >> 1;
        if (state_q == DATA) crc_d = crc_b;
      end
      if (!stuff_q && ones_n == 3'd6) begin
        stuff_d = 1'b1;
        ones_d = 3'd0;
      end else if (bit_n == 4'd8) begin
        bit_d = 4'd0;
        case (state_q)
          SYNC: begin
            state_d = PID;
            sh_d = pkt_q == 2'd1 ? 8'hC3 : pkt_q == 2'd2 ? 8'hD2 : 8'h5A;
            crc_d = 16'hFFFF;
          end
          PID, DATA: begin
            state_d = pkt_q != 2'd1 ? EOP : more ? DATA : CRC_LO;
            sh_d = ~crc_d[7:0];
          end
          CRC_LO: begin
            state_d = CRC_HI;
            sh_d = ~crc_q[15:8];
          end
          default: state_d = EOP;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      bit_q <= 4'd0;
      ones_q <= 3'd0;
      stuff_q <= 1'b0;
      lvl_q <= 1'b1;
      sh_q <= 8'h00;
      crc_q <= 16'hFFFF;
      pkt_q <= 2'd0;
      cnt_q <= 7'd0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      ones_q <= ones_d;
      stuff_q <= stuff_d;
      lvl_q <= lvl_d;
      sh_q <= sh_d;
      crc_q <= crc_d;
      pkt_q <= pkt_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.get_TX_packet_data = load;
  assign bus.dp_out = state_q == IDLE ? 1'b1 : state_q == EOP ? bit_q == 4'd2 : drv;
  assign bus.dm_out = state_q == IDLE || state_q == EOP ? 1'b0 : ~drv;
  assign bus.TX_transfer_active = busy;
  assign bus.TX_error = busy && bus.TX_packet != 2'd0;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: table-driven and randomized packets checked cycle by cycle
// against a bit-queue model of SYNC/PID/payload/CRC, stuffing, NRZI and EOP.
module tb_usb_tx_encoder;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  usb_tx_encoder_if bus();
  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  logic [7:0] mem [64];
  int pops = 0;
  int pop_base = 0;
  int occ0 = 0;
  int idx;
  assign idx = pops - pop_base;
  assign bus.TX_packet_data = mem[idx[5:0]];
  assign bus.buffer_occupancy = 7'(occ0 - idx);
  always @(posedge clk) if (bus.get_TX_packet_data) pops <= pops + 1;
  int errors = 0;
  int checks = 0;
  int exp_sym[$];
  int exp_pop[$];
  typedef struct {
    int typ, n, mode, err_at, err_val, len, npops;
  } vec_t;
  vec_t tbl[7];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // symbols: 0 = SE0, 1 = J, 2 = K, 3 = illegal SE1
  function automatic int line_sym();
    return bus.dp_out && !bus.dm_out ? 1 : !bus.dp_out && bus.dm_out ? 2 :
           !bus.dp_out && !bus.dm_out ? 0 : 3;
  endfunction
  task automatic build_model(input int typ, input int n);
    int pb[$];
    int start[$];
    int out[$];
    bit [15:0] crc;
    bit [7:0] pid;
    bit v;
    int run;
    int lvl;
    crc = 16'hFFFF;
    run = 0;
    lvl = 1;
    pid = typ == 1 ? 8'hC3 : typ == 2 ? 8'hD2 : 8'h5A;
    for (int i = 0; i < 8; i++) pb.push_back(i == 7 ? 1 : 0);
    for (int i = 0; i < 8; i++) pb.push_back(int'(pid[i]));
    if (typ == 1) begin
      for (int b = 0; b < n; b++) begin
        start.push_back(pb.size());
        for (int i = 0; i < 8; i++) begin
          v = mem[b][i];
          pb.push_back(int'(v));
          crc = (crc[0] ^ v) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        end
      end
      crc = ~crc;
      for (int i = 0; i < 16; i++) pb.push_back(int'(crc[i]));
    end
    exp_sym.delete();
    exp_pop.delete();
    for (int i = 0; i < pb.size(); i++) begin
      if (start.size() > 0 && start[0] == i) begin
        exp_pop.push_back(out.size() * CPB);
        void'(start.pop_front());
      end
      out.push_back(pb[i]);
      run = pb[i] != 0 ? run + 1 : 0;
      if (run == 6) begin
        out.push_back(0);
        run = 0;
      end
    end
    foreach (out[i]) begin
      if (out[i] == 0) lvl = 3 - lvl;
      exp_sym.push_back(lvl);
    end
    exp_sym.push_back(0);
    exp_sym.push_back(0);
    exp_sym.push_back(1);
  endtask
  task automatic send(input string name, input int typ, input int n, input int mode,
                      input int err_at, input int err_val, input int tbl_len, input int tbl_pops);
    int wave_bad, bad_first, act_len, nerr, pop_bad, total, s, es;
    int got[$];
    wave_bad = 0;
    bad_first = -1;
    act_len = 0;
    nerr = 0;
    pop_bad = 0;
    for (int b = 0; b < 64; b++) mem[b] = mode == 0 ? 8'(b) : mode == 1 ? 8'hFF : 8'($urandom);
    pop_base = pops;
    occ0 = n;
    build_model(typ, n);
    total = exp_sym.size() * CPB;
    bus.TX_packet = 2'(typ);
    @(posedge clk);
    #1;
    for (int c = 0; c < total + 3 * CPB; c++) begin
      bus.TX_packet = c == err_at ? 2'(err_val) : 2'd0;
      @(negedge clk);
      s = line_sym();
      es = c < total ? exp_sym[c / CPB] : 1;
      if (s != es || bus.TX_transfer_active !== (c < total)) begin
        wave_bad++;
        if (bad_first < 0) bad_first = c;
      end
      act_len += int'(bus.TX_transfer_active);
      nerr += int'(bus.TX_error);
      if (bus.get_TX_packet_data) begin
        got.push_back(c);
        if (bus.buffer_occupancy == 7'd0) pop_bad++;
      end
      @(posedge clk);
      #1;
    end
    if (got.size() != exp_pop.size()) pop_bad++;
    else foreach (got[i]) if (got[i] != exp_pop[i]) pop_bad++;
    check($sformatf("%s wave (first bad cycle %0d)", name, bad_first), wave_bad, 0);
    check($sformatf("%s active cycles", name), act_len, total);
    check($sformatf("%s pop count", name), got.size(), exp_pop.size());
    check($sformatf("%s pop timing", name), pop_bad, 0);
    check($sformatf("%s error pulses", name), nerr, err_at >= 0 && err_val != 0 ? 1 : 0);
    if (tbl_len > 0) check($sformatf("%s table length", name), act_len, tbl_len);
    if (tbl_pops >= 0) check($sformatf("%s table pops", name), got.size(), tbl_pops);
  endtask
  task automatic check_idle(input string name);
    check({name, " dp"}, int'(bus.dp_out), 1);
    check({name, " dm"}, int'(bus.dm_out), 0);
    check({name, " active"}, int'(bus.TX_transfer_active), 0);
    check({name, " pop"}, int'(bus.get_TX_packet_data), 0);
    check({name, " error"}, int'(bus.TX_error), 0);
  endtask
  initial begin
    bus.TX_packet = 2'd0;
    for (int b = 0; b < 64; b++) mem[b] = 8'h00;
    tbl[0] = '{2, 0, 0, -1, 0, 76, 0};
    tbl[1] = '{3, 0, 0, -1, 0, 76, 0};
    tbl[2] = '{1, 0, 0, -1, 0, 140, 0};
    tbl[3] = '{1, 1, 1, -1, 0, 180, 1};
    tbl[4] = '{1, 64, 0, -1, 0, 0, 64};
    tbl[5] = '{1, 4, 0, 100, 3, 0, 4};
    tbl[6] = '{2, 0, 0, 40, 2, 76, 0};
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("idle after reset");
    foreach (tbl[i])
      send($sformatf("vec%0d", i), tbl[i].typ, tbl[i].n, tbl[i].mode,
           tbl[i].err_at, tbl[i].err_val, tbl[i].len, tbl[i].npops);
    for (int r = 0; r < 20; r++) begin
      int typ, n, ea, ev;
      typ = int'($urandom_range(1, 3));
      n = r == 7 ? 64 : int'($urandom_range(0, 12));
      ea = int'($urandom_range(1, 60));
      ev = int'($urandom_range(0, 3));
      send($sformatf("rand%0d", r), typ, n, 2, ea, ev, 0, -1);
    end
    for (int b = 0; b < 64; b++) mem[b] = 8'(b * 7);
    pop_base = pops;
    occ0 = 8;
    bus.TX_packet = 2'd1;
    @(posedge clk);
    #1;
    bus.TX_packet = 2'd0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("mid-data active before reset", int'(bus.TX_transfer_active), 1);
    n_rst = 1'b0;
    #1;
    check_idle("async reset mid-data");
    @(posedge clk);
    #1;
    check_idle("held in reset");
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    send("ack after reset", 2, 0, 0, -1, 0, 76, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, number of clk cycles per USB bit time (48 MHz clk, 12 Mb/s line).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: n_rst  input  1  asynchronous, active-low reset.
REQ-004 Port: TX_packet  input  2  request: 0 none, 1 DATA0, 2 ACK, 3 NAK.
REQ-005 Port: buffer_occupancy  input  7  bytes held in the upstream data buffer, 0..64.
REQ-006 Port: TX_packet_data  input  8  payload byte from the data buffer, valid combinationally in the cycle get_TX_packet_data is high.
REQ-007 Port: get_TX_packet_data  output  1  one-cycle pop strobe to the data buffer.
REQ-008 Port: dp_out  output  1  D+ line drive.
REQ-009 Port: dm_out  output  1  D- line drive.
REQ-010 Port: TX_transfer_active  output  1  high while a packet is on the line.
REQ-011 Port: TX_error  output  1  one-cycle pulse: request dropped because the encoder was busy.

Function
REQ-012 States SHALL be IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP; a bit-timer (0..CLKS_PER_BIT-1) paces every non-IDLE state, and field transitions occur only at bit-time boundaries.
REQ-013 In IDLE, nonzero TX_packet sampled at edge k SHALL be latched, and the first SYNC bit SHALL be driven from cycle k+1; TX_transfer_active SHALL rise in cycle k+1.
REQ-014 Nonzero TX_packet outside IDLE SHALL be ignored and SHALL pulse TX_error for that one cycle.
REQ-015 SYNC SHALL be the bit sequence 0,0,0,0,0,0,0,1 (byte 0x80, LSB first).
REQ-016 PID byte SHALL be 0xC3 (DATA0), 0xD2 (ACK), or 0x5A (NAK), sent LSB first; ACK/NAK go PID -> EOP.
REQ-017 DATA0: after PID, if buffer_occupancy > 0, assert get_TX_packet_data for exactly one cycle (the first cycle of the byte's first bit time), capture TX_packet_data that cycle, and shift it LSB first; repeat per byte; when buffer_occupancy reads 0 at a byte boundary, go to CRC_LO (zero-length payload allowed).
REQ-018 get_TX_packet_data SHALL never be asserted when buffer_occupancy is 0, and at most 64 times per packet.
REQ-019 CRC16: polynomial 0x8005, reflected (LSB-first) over payload bits only, seed 0xFFFF at PID start; the ones-complement of the remainder SHALL be sent as CRC_LO then CRC_HI, LSB first.
REQ-020 Bit stuffing: ones-run counter cleared at SYNC start; after six consecutive pre-encoding 1s a 0 SHALL be inserted, occupying one full bit time, not fed to the CRC, and resetting the counter; applies SYNC through the last CRC bit, including a stuff bit after the final CRC bit.
REQ-021 NRZI: a 0 bit toggles the line state, a 1 bit holds it; line state is J (dp=1, dm=0) entering SYNC.
REQ-022 EOP: SE0 (dp=0, dm=0) for two bit times, then J for one bit time, then IDLE; TX_transfer_active SHALL fall in the first IDLE cycle.
REQ-023 IDLE SHALL drive J, get_TX_packet_data=0, TX_error=0.
REQ-024 The latched packet type SHALL be held stable for the whole packet; TX_packet changes mid-packet SHALL not alter it.

Reset
REQ-025 On n_rst low, asynchronously: state IDLE, dp_out=1, dm_out=0, get_TX_packet_data=0, TX_transfer_active=0, TX_error=0, CRC=0xFFFF, counters 0.
REQ-026 Reset mid-packet SHALL abort immediately to J with no EOP; the next request after release SHALL start a clean SYNC.

Verification
REQ-027 ACK: TX_packet=2 one cycle -> pre-NRZI bits 00000001 01001011 then SE0,SE0,J; 19 bit times = 76 clks active; no pop.
REQ-028 Empty DATA0: occupancy=0, TX_packet=1 -> SYNC, 0xC3, CRC bytes 0x00,0x00 (16 zeros, no stuffing), EOP; 35 bit times; get_TX_packet_data never high.
REQ-029 DATA0 single 0xFF: occupancy=1 -> one pop in first cycle of DATA; stuff 0 inserted after 4th data bit (PID ends 1,1); CRC matches a software model.
REQ-030 DATA0 64 bytes (0x00..0x3F), occupancy stepping 64->0 -> exactly 64 pops, each spaced 8 bit times plus any stuff bits; CRC matches model.
REQ-031 TX_packet=3 asserted during an active DATA0 -> one-cycle TX_error pulse; line waveform identical to undisturbed run.
REQ-032 n_rst low mid-DATA -> dp=1, dm=0 same cycle, TX_transfer_active=0; subsequent ACK request matches REQ-027.
